// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - shared network-interface beat types and widths
package ni_pkg;

    localparam int NI_ADDR_W = 32;
    localparam int NI_DATA_W = 32;
    localparam int NI_BEAT_W = NI_ADDR_W + NI_DATA_W;

    typedef struct packed {
        logic [NI_ADDR_W-1:0] addr;
        logic [NI_DATA_W-1:0] data;
    } ni_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last grant
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid   = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ni_wr_arbiter.sv
// rtl/ni_wr_arbiter.sv - round-robin share of the NI write FIFO port with a one-beat output stage
// Optional grant locking for bursts of up to MAX_BURST beats: NI_WR_ARB_LOCK_EN
module ni_wr_arbiter
    import ni_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = NI_BEAT_W,
    parameter int MAX_BURST = 4
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_write_en,
    output logic [DATA_W-1:0]           fifo_write_data,
    input  logic                        fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end
    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
        $error("MAX_BURST out of range");
    end

    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   grant_hold;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               stage_free;
    logic               xfer;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req         (req_valid),
        .last        (rr_last),
        .grant_oh    (arb_oh),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

`ifdef NI_WR_ARB_LOCK_EN
    logic             lock_active;
    logic [IDX_W-1:0] lock_id;
    logic [3:0]       beat_cnt;
    logic             lock_hold;
    logic [4:0]       cnt_next;

    assign lock_hold = lock_active && req_valid[lock_id];
    assign cnt_next  = lock_hold ? ({1'b0, beat_cnt} + 5'd1) : 5'd1;

    always_comb begin
        gnt_oh    = arb_oh;
        gnt_idx   = arb_idx;
        gnt_valid = arb_valid;
        if (lock_hold) begin
            gnt_oh          = '0;
            gnt_oh[lock_id] = 1'b1;
            gnt_idx         = lock_id;
            gnt_valid       = 1'b1;
        end
    end

    // Stalled cycles never transfer, so they leave the burst count untouched.
    always_ff @(posedge aclk) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_id     <= '0;
            beat_cnt    <= '0;
        end else if (xfer) begin
            lock_id <= gnt_idx;
            if (cnt_next >= 5'(MAX_BURST)) begin
                lock_active <= 1'b0;
                beat_cnt    <= '0;
            end else begin
                lock_active <= 1'b1;
                beat_cnt    <= cnt_next[3:0];
            end
        end else if (lock_active && !lock_hold) begin
            lock_active <= 1'b0;
            beat_cnt    <= '0;
        end
    end
`else
    assign gnt_oh    = arb_oh;
    assign gnt_idx   = arb_idx;
    assign gnt_valid = arb_valid;
`endif

    assign stage_free      = !out_valid || !fifo_full;
    assign req_ready       = (!reset && stage_free) ? (gnt_oh & req_valid) : '0;
    assign xfer            = |req_ready;
    assign fifo_write_en   = !reset && out_valid && !fifo_full;
    assign fifo_write_data = out_data;
    assign busy            = out_valid;
    assign grant_id        = (!reset && gnt_valid) ? gnt_idx : grant_hold;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A load in the same cycle as a drain simply replaces the outgoing beat.
    always_ff @(posedge aclk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            rr_last    <= IDX_W'(NUM_REQ - 1);
            grant_hold <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                rr_last   <= gnt_idx;
            end else if (fifo_write_en) begin
                out_valid <= 1'b0;
            end
            if (gnt_valid) begin
                grant_hold <= gnt_idx;
            end
        end
    end

endmodule

// File: doc/ni_wr_arbiter.md
Name: ni_wr_arbiter

Overview:
- Round-robin arbiter that shares the network-interface injection FIFO write port among NUM_REQ requesters.
- Requesters are typically AXI4-lite slave front-ends, each producing 64-bit {addr[31:0], data[31:0]} beats.
- Grants one requester per beat and registers the winning beat into a one-entry output stage that drains into the FIFO under `fifo_full` back-pressure.
- Sits between the AXI4-lite slaves and the NI write FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, beat width ({awaddr, wdata}).
- MAX_BURST, 4, maximum consecutive beats per grant when the lock feature is compiled in (1..16).

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock aclk.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  packed beats; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- fifo_write_en  out  1  write strobe to NI FIFO.
- fifo_write_data  out  DATA_W  beat written to FIFO.
- fifo_full  in  1  FIFO full; a write is ignored by the FIFO when high.
- grant_id  out  $clog2(NUM_REQ)  index of the current grant holder (debug/monitor).
- busy  out  1  output stage holds a beat.

Behaviour:
- Reset values:
  - req_ready = 0, fifo_write_en = 0, fifo_write_data = 0, busy = 0, grant_id = 0.
  - Round-robin pointer rr_last = NUM_REQ-1, so requester 0 has first priority.
- Output stage:
  - Register out_valid/out_data; busy = out_valid.
  - fifo_write_en = out_valid && !fifo_full (combinational).
  - fifo_write_data = out_data.
  - The stage drains in the same cycle fifo_write_en is high.
- Accept condition:
  - stage_free = !out_valid || !fifo_full.
  - req_ready[i] = stage_free && (grant == i) && req_valid[i].
  - A transfer occurs when req_valid[i] && req_ready[i].
  - The beat is loaded into out_data on that edge and fifo_write_en may assert the next cycle: 1-cycle latency.
  - With the FIFO never full: one beat per cycle sustained, back-to-back.
- Arbitration (combinational):
  - Search req_valid starting at index rr_last+1, wrapping modulo NUM_REQ; the first set bit wins.
  - No valid request → no grant; grant_id holds its last value.
  - On each transfer, rr_last <= winner.
  - A requester that keeps valid asserted yields to any other valid requester after one beat.
- Back-pressure:
  - While out_valid && fifo_full: all req_ready = 0 and out_data is held stable.
  - No beat is ever dropped or overwritten.
- Simultaneous events:
  - Drain and load in the same cycle is allowed; out_valid stays 1 with the new data.
  - A requester dropping valid before ready: no transfer, and the pointer is unchanged.
- Requester obligations:
  - Requesters must hold req_data stable while req_valid is high and req_ready is low.
  - Arbiter behaviour is undefined otherwise.
- Reset mid-operation:
  - The output stage is cleared and the held beat discarded; the pointer returns to NUM_REQ-1.
  - fifo_write_en is 0 during the reset cycle.

Optional Feature:
- Macro: NI_WR_ARB_LOCK_EN.
- Defined:
  - The grant is held on the current winner for up to MAX_BURST consecutive transfers while its req_valid remains high.
  - A 4-bit beat counter resets on grant change.
  - Release happens on the MAX_BURST-th transfer or when valid drops; rr_last then updates to the winner.
  - Other requesters wait during a lock.
  - Back-pressure stalls do not count toward MAX_BURST.
- Undefined: strict per-beat round-robin as above; the counter logic is absent.

Decomposition:
- Package ni_pkg:
  - NI_BEAT_W = 64.
  - NI_ADDR_W = 32, NI_DATA_W = 32.
  - Beat typedef ni_beat_t (struct {addr, data}).
- Sub-module rr_arbiter(N):
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational; reusable for the read-side scheduler.
- Top level holds the pointer, output stage and lock counter.

Test Plan:
- Reset: assert reset 2 cycles with all req_valid=1 → req_ready=0, fifo_write_en=0, busy=0; first grant after release goes to requester 0.
- Fairness: req_valid=4'b1111, fifo_full=0, distinct data per requester → FIFO writes in order 0,1,2,3,0,1… one per cycle, each appearing 1 cycle after its accept.
- Wrap/sparse: only req 1 and 3 valid, rr_last=3 → grant order 1,3,1,3; a lone requester 2 is accepted every cycle.
- Back-pressure: fifo_full=1 after one accepted beat 0xDEAD_BEEF_0000_0001 → fifo_write_en=0, all req_ready=0, data held. Release full → written exactly once, next beat accepted the same cycle.
- Mid-operation reset: reset while busy=1 and fifo_full=1 → held beat never written; pointer back to NUM_REQ-1.
- Lock (NI_WR_ARB_LOCK_EN, MAX_BURST=4): req 0 and 1 continuously valid → writes 0,0,0,0,1,1,1,1. A 2-cycle fifo_full stall inside a burst still yields exactly 4 beats from req 0.
